stepper_ramp_gen: RTL and testbench

Move-command front end for the stepper path. Accepts a move (direction, step count, target speed) over a valid/ready handshake and drives `stepper_motor`'s `in_dir`, `in_en` and `in_cycles`. It shapes the per-step period into an accel/cruise/decel trapezoid, counts completed steps, and signals completion.

---
 rtl/stepper_pkg.sv | 27 ++
 rtl/stepper_step_timer.sv | 34 +++
 rtl/stepper_ramp_gen.sv | 197 +++++++++++++++++++
 tb/tb_stepper_ramp_gen.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared types and helpers for the stepper move-command path.
// Used by stepper_ramp_gen and stepper_step_timer.
package stepper_pkg;

  // Default widths of period values and step counts.
  localparam int DEF_CYC_W  = 10;
  localparam int DEF_STEP_W = 16;

  // Move sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEL,
    ST_CRUISE,
    ST_DECEL,
    ST_DONE
  } ramp_state_t;

  // Limit a requested period to the legal [lo, hi] window.
  function automatic int unsigned clamp_cyc(input int unsigned cyc,
                                            input int unsigned lo,
                                            input int unsigned hi);
    if (cyc < lo) return lo;
    if (cyc > hi) return hi;
    return cyc;
  endfunction

endpackage

// File: rtl/stepper_step_timer.sv
// Per-step period counter. Counts clocks while enabled and strobes on the
// last clock of each step, then restarts from zero. Held at zero when
// disabled, so every move starts with a fresh count.
module stepper_step_timer
  import stepper_pkg::*;
#(
  parameter int CYC_W = DEF_CYC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CYC_W-1:0] period,
  output logic             step_done
);

  logic [CYC_W-1:0] count;

  // The strobe marks the edge on which the current step completes.
  assign step_done = en && (count == period - CYC_W'(1));

  // Period counter: clear when idle or at step completion, else count up.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      count <= '0;
    end else if (!en || step_done) begin
      count <= '0;
    end else begin
      count <= count + CYC_W'(1);
    end
  end

endmodule

// File: rtl/stepper_ramp_gen.sv
// Move-command front end for the stepper path: accepts a move over a
// valid/ready handshake, shapes the per-step period into an
// accel/cruise/decel trapezoid and drives stepper_motor's dir/en/cycles.
// Build option: define STEPPER_RAMP_EN for the trapezoid; without it every
// step of a move runs at the clamped target period.
module stepper_ramp_gen
  import stepper_pkg::*;
#(
  parameter int          CYC_W    = DEF_CYC_W,
  parameter int          STEP_W   = DEF_STEP_W,
  parameter int unsigned MIN_CYC  = 100,
  parameter int unsigned MAX_CYC  = 1000,
  parameter int unsigned ACC_STEP = 8
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_cmd_valid,
  output logic              out_cmd_ready,
  input  logic              in_cmd_dir,
  input  logic [STEP_W-1:0] in_cmd_steps,
  input  logic [CYC_W-1:0]  in_cmd_cycles,
  input  logic              in_stop,
  output logic              out_dir,
  output logic              out_en,
  output logic [CYC_W-1:0]  out_cycles,
  output logic              out_step,
  output logic              out_busy,
  output logic              out_done
);

  // Reject parameter sets that would make the period arithmetic meaningless.
  if (MIN_CYC < 1 || MAX_CYC <= MIN_CYC || ACC_STEP < 1 ||
      MAX_CYC > (32'd1 << CYC_W) - 32'd1) begin : g_param_check
    $error("stepper_ramp_gen: inconsistent MIN_CYC/MAX_CYC/ACC_STEP/CYC_W");
  end

  localparam logic [CYC_W-1:0] MAX_P = CYC_W'(MAX_CYC);

  ramp_state_t       state, state_n;
  logic              dir_n, en_n, busy_n, step_n, done_n;
  logic [CYC_W-1:0]  cycles_n;
  logic [STEP_W-1:0] remaining, remaining_n, rem_dec;
  logic [CYC_W-1:0]  cmd_target;
  logic              step_done;

  assign cmd_target    = CYC_W'(clamp_cyc(32'(in_cmd_cycles), MIN_CYC, MAX_CYC));
  assign rem_dec       = remaining - STEP_W'(1);
  assign out_cmd_ready = (state == ST_IDLE) && !in_rst;

`ifdef STEPPER_RAMP_EN
  localparam logic [CYC_W:0]   MAX_X = (CYC_W+1)'(MAX_CYC);
  localparam logic [CYC_W:0]   ACC_X = (CYC_W+1)'(ACC_STEP);
  localparam logic [CYC_W-1:0] ACC_P = CYC_W'(ACC_STEP);

  logic [STEP_W-1:0] acc, acc_n;
  logic [CYC_W-1:0]  target, target_n;
  logic [CYC_W:0]    up_sum;
  logic [CYC_W-1:0]  up_p, down_p;

  // Ramp arithmetic runs one bit wider than the period so it cannot wrap.
  assign up_sum = {1'b0, out_cycles} + ACC_X;
  assign up_p   = (up_sum > MAX_X) ? MAX_P : up_sum[CYC_W-1:0];
  assign down_p = ({1'b0, out_cycles} >= ({1'b0, target} + ACC_X))
                  ? (out_cycles - ACC_P) : target;
`endif

  stepper_step_timer #(
    .CYC_W (CYC_W)
  ) u_timer (
    .clk       (in_clk),
    .rst       (in_rst),
    .en        (out_en),
    .period    (out_cycles),
    .step_done (step_done)
  );

  // Next-state and next-output logic for the move sequencer.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_n     = state;
    dir_n       = out_dir;
    en_n        = out_en;
    busy_n      = out_busy;
    cycles_n    = out_cycles;
    step_n      = 1'b0;
    done_n      = 1'b0;
    remaining_n = remaining;
`ifdef STEPPER_RAMP_EN
    acc_n       = acc;
    target_n    = target;
`endif

    unique case (state)
      ST_IDLE: begin
        if (in_cmd_valid) begin
          dir_n       = in_cmd_dir;
          remaining_n = in_cmd_steps;
`ifdef STEPPER_RAMP_EN
          target_n    = cmd_target;
          acc_n       = '0;
          cycles_n    = MAX_P;
`else
          cycles_n    = cmd_target;
`endif
          if (in_cmd_steps == '0) begin
            // Nothing to move: report completion without enabling the motor.
            state_n  = ST_DONE;
            done_n   = 1'b1;
            en_n     = 1'b0;
            busy_n   = 1'b0;
            cycles_n = MAX_P;
          end else begin
            en_n   = 1'b1;
            busy_n = 1'b1;
`ifdef STEPPER_RAMP_EN
            // A target at the start/stop period needs no ramp at all.
            state_n = (cmd_target == MAX_P) ? ST_CRUISE : ST_ACCEL;
`else
            state_n = ST_CRUISE;
`endif
          end
        end
      end

      ST_ACCEL, ST_CRUISE, ST_DECEL: begin
        if (in_stop) begin
          state_n  = ST_IDLE;
          en_n     = 1'b0;
          busy_n   = 1'b0;
          cycles_n = MAX_P;
        end else if (step_done) begin
          step_n      = 1'b1;
          remaining_n = rem_dec;
          if (rem_dec == '0) begin
            state_n  = ST_DONE;
            done_n   = 1'b1;
            en_n     = 1'b0;
            busy_n   = 1'b0;
            cycles_n = MAX_P;
          end
`ifdef STEPPER_RAMP_EN
          // Decelerate once the steps left only cover the ramp back down.
          else if (state == ST_DECEL || rem_dec <= acc) begin
            state_n  = ST_DECEL;
            cycles_n = up_p;
          end else if (state == ST_ACCEL) begin
            cycles_n = down_p;
            acc_n    = (acc == '1) ? acc : acc + STEP_W'(1);
            if (down_p == target) state_n = ST_CRUISE;
          end
`endif
        end
      end

      ST_DONE: begin
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Register state and all outputs; synchronous reset has top priority.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state      <= ST_IDLE;
      out_dir    <= 1'b0;
      out_en     <= 1'b0;
      out_busy   <= 1'b0;
      out_cycles <= MAX_P;
      out_step   <= 1'b0;
      out_done   <= 1'b0;
      remaining  <= '0;
`ifdef STEPPER_RAMP_EN
      acc        <= '0;
      target     <= MAX_P;
`endif
    end else begin
      state      <= state_n;
      out_dir    <= dir_n;
      out_en     <= en_n;
      out_busy   <= busy_n;
      out_cycles <= cycles_n;
      out_step   <= step_n;
      out_done   <= done_n;
      remaining  <= remaining_n;
`ifdef STEPPER_RAMP_EN
      acc        <= acc_n;
      target     <= target_n;
`endif
    end
  end

endmodule

// File: tb/tb_stepper_ramp_gen.sv
// Directed bench for stepper_ramp_gen with MIN_CYC=4, MAX_CYC=20,
// ACC_STEP=4. Expected step periods follow STEPPER_RAMP_EN.
`timescale 1ns/1ps
module tb_stepper_ramp_gen;

  localparam int          CYC_W    = 10;
  localparam int          STEP_W   = 16;
  localparam int unsigned MIN_CYC  = 4;
  localparam int unsigned MAX_CYC  = 20;
  localparam int unsigned ACC_STEP = 4;

  logic              in_clk = 1'b0;
  logic              in_rst = 1'b1;
  logic              in_cmd_valid = 1'b0;
  logic              in_cmd_dir = 1'b0;
  logic [STEP_W-1:0] in_cmd_steps = '0;
  logic [CYC_W-1:0]  in_cmd_cycles = '0;
  logic              in_stop = 1'b0;
  logic              out_cmd_ready, out_dir, out_en, out_step, out_busy, out_done;
  logic [CYC_W-1:0]  out_cycles;

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  always #5 in_clk = ~in_clk;

  stepper_ramp_gen #(
    .CYC_W    (CYC_W),
    .STEP_W   (STEP_W),
    .MIN_CYC  (MIN_CYC),
    .MAX_CYC  (MAX_CYC),
    .ACC_STEP (ACC_STEP)
  ) dut (
    .in_clk        (in_clk),
    .in_rst        (in_rst),
    .in_cmd_valid  (in_cmd_valid),
    .out_cmd_ready (out_cmd_ready),
    .in_cmd_dir    (in_cmd_dir),
    .in_cmd_steps  (in_cmd_steps),
    .in_cmd_cycles (in_cmd_cycles),
    .in_stop       (in_stop),
    .out_dir       (out_dir),
    .out_en        (out_en),
    .out_cycles    (out_cycles),
    .out_step      (out_step),
    .out_busy      (out_busy),
    .out_done      (out_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  // Issue one move and track it to completion against exp_q.
  task automatic run_move(input string tag, input logic dir, input int steps,
                          input int cycles, input int exp_en);
    int nstep = 0;
    int len = 0;
    int en_cyc = 0;
    int budget = 0;
    int expv;
    bit finished = 1'b0;
    while (!out_cmd_ready && budget < 100) begin
      tick();
      budget++;
    end
    check({tag, "_ready_before"}, 32'(out_cmd_ready), 1);
    in_cmd_valid  = 1'b1;
    in_cmd_dir    = dir;
    in_cmd_steps  = STEP_W'(steps);
    in_cmd_cycles = CYC_W'(cycles);
    tick();
    in_cmd_valid = 1'b0;
    check({tag, "_ready_after_accept"}, 32'(out_cmd_ready), 0);
    check({tag, "_dir"}, 32'(out_dir), 32'(dir));
    budget = 0;
    while (!finished && budget < 3000) begin
      if (out_step) begin
        expv = (nstep < exp_q.size()) ? exp_q[nstep] : -1;
        check($sformatf("%s_len%0d", tag, nstep), len, expv);
        nstep++;
        len = 0;
      end
      if (out_done) begin
        finished = 1'b1;
      end else begin
        if (out_en) begin
          if (len == 0) begin
            expv = (nstep < exp_q.size()) ? exp_q[nstep] : -1;
            check($sformatf("%s_cycles%0d", tag, nstep), 32'(out_cycles), expv);
          end
          len++;
          en_cyc++;
        end
        tick();
        budget++;
      end
    end
    check({tag, "_finished"}, 32'(finished), 1);
    check({tag, "_done_en"}, 32'(out_en), 0);
    check({tag, "_done_busy"}, 32'(out_busy), 0);
    check({tag, "_done_step"}, 32'(out_step), (steps != 0) ? 1 : 0);
    check({tag, "_done_cycles"}, 32'(out_cycles), MAX_CYC);
    check({tag, "_nsteps"}, nstep, steps);
    check({tag, "_en_cycles"}, en_cyc, exp_en);
    tick();
    check({tag, "_done_width"}, 32'(out_done), 0);
    check({tag, "_ready_after_done"}, 32'(out_cmd_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nstep;
    int budget;
    bit seen;

    // Reset values.
    tick();
    tick();
    check("rst_en", 32'(out_en), 0);
    check("rst_busy", 32'(out_busy), 0);
    check("rst_dir", 32'(out_dir), 0);
    check("rst_cycles", 32'(out_cycles), MAX_CYC);
    check("rst_step", 32'(out_step), 0);
    check("rst_done", 32'(out_done), 0);
    check("rst_ready_in_reset", 32'(out_cmd_ready), 0);
    in_rst = 1'b0;
    #1;
    check("rst_ready_released", 32'(out_cmd_ready), 1);

    // Trapezoid.
`ifdef STEPPER_RAMP_EN
    exp_q = '{20, 16, 12, 8, 4, 4, 8, 12, 16, 20};
    run_move("trap", 1'b1, 10, 4, 120);
`else
    exp_q = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
    run_move("trap", 1'b1, 10, 4, 40);
`endif

    // Triangle.
`ifdef STEPPER_RAMP_EN
    exp_q = '{20, 16, 12, 16};
    run_move("tri", 1'b0, 4, 4, 64);
`else
    exp_q = '{4, 4, 4, 4};
    run_move("tri", 1'b0, 4, 4, 16);
`endif

    // Target below MIN_CYC clamps up to 4.
`ifdef STEPPER_RAMP_EN
    exp_q = '{20, 16};
    run_move("clamp_lo", 1'b1, 2, 1, 36);
`else
    exp_q = '{4, 4};
    run_move("clamp_lo", 1'b1, 2, 1, 8);
`endif

    // Target above MAX_CYC clamps down to 20 and cruises there.
    exp_q = '{20, 20};
    run_move("clamp_hi", 1'b0, 2, 25, 40);

    // Zero-step command.
    exp_q.delete();
    run_move("zero", 1'b1, 0, 8, 0);

    // Short move used for the ramp-disabled comparison.
`ifdef STEPPER_RAMP_EN
    exp_q = '{20, 16, 20};
    run_move("short", 1'b0, 3, 6, 56);
`else
    exp_q = '{6, 6, 6};
    run_move("short", 1'b0, 3, 6, 18);
`endif

    // Abort during step 3 of a 10-step move.
    in_cmd_valid  = 1'b1;
    in_cmd_dir    = 1'b1;
    in_cmd_steps  = STEP_W'(10);
    in_cmd_cycles = CYC_W'(4);
    tick();
    in_cmd_valid = 1'b0;
    nstep = 0;
    budget = 0;
    while (nstep < 2 && budget < 500) begin
      if (out_step) nstep++;
      if (nstep < 2) tick();
      budget++;
    end
    check("abort_reached_step3", nstep, 2);
    tick();
    in_stop = 1'b1;
    tick();
    in_stop = 1'b0;
    check("abort_en", 32'(out_en), 0);
    check("abort_busy", 32'(out_busy), 0);
    check("abort_cycles", 32'(out_cycles), MAX_CYC);
    check("abort_done", 32'(out_done), 0);
    check("abort_step", 32'(out_step), 0);
    check("abort_ready", 32'(out_cmd_ready), 1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_done || out_en) seen = 1'b1;
    end
    check("abort_quiet", 32'(seen), 0);

    // Held valid: the second command waits for IDLE, then goes immediately.
    in_cmd_valid  = 1'b1;
    in_cmd_dir    = 1'b0;
    in_cmd_steps  = STEP_W'(2);
    in_cmd_cycles = CYC_W'(20);
    tick();
    check("hs_busy", 32'(out_busy), 1);
    in_cmd_steps  = STEP_W'(1);
    in_cmd_cycles = CYC_W'(4);
    nstep = 0;
    budget = 0;
    seen = 1'b0;
    while (!out_done && budget < 500) begin
      if (out_step) nstep++;
      if (out_cmd_ready) seen = 1'b1;
      tick();
      budget++;
    end
    if (out_step) nstep++;
    check("hs_first_done", 32'(out_done), 1);
    check("hs_first_steps", nstep, 2);
    check("hs_no_ready_midmove", 32'(seen), 0);
    tick();
    check("hs_ready_idle", 32'(out_cmd_ready), 1);
    tick();
    in_cmd_valid = 1'b0;
    check("hs_second_busy", 32'(out_busy), 1);
    check("hs_second_ready", 32'(out_cmd_ready), 0);
`ifdef STEPPER_RAMP_EN
    check("hs_second_cycles", 32'(out_cycles), 20);
`else
    check("hs_second_cycles", 32'(out_cycles), 4);
`endif
    nstep = 0;
    budget = 0;
    while (!out_done && budget < 500) begin
      if (out_step) nstep++;
      tick();
      budget++;
    end
    if (out_step) nstep++;
    check("hs_second_steps", nstep, 1);
    tick();

    // Reset in the middle of a cruise.
    in_cmd_valid  = 1'b1;
    in_cmd_dir    = 1'b1;
    in_cmd_steps  = STEP_W'(10);
    in_cmd_cycles = CYC_W'(20);
    tick();
    in_cmd_valid = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    check("mid_en", 32'(out_en), 1);
    in_rst = 1'b1;
    tick();
    check("mrst_en", 32'(out_en), 0);
    check("mrst_busy", 32'(out_busy), 0);
    check("mrst_dir", 32'(out_dir), 0);
    check("mrst_cycles", 32'(out_cycles), MAX_CYC);
    check("mrst_step", 32'(out_step), 0);
    check("mrst_done", 32'(out_done), 0);
    check("mrst_ready", 32'(out_cmd_ready), 0);
    in_rst = 1'b0;
    #1;
    check("mrst_ready_released", 32'(out_cmd_ready), 1);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_en || out_step || out_done) seen = 1'b1;
    end
    check("mrst_quiet", 32'(seen), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
